// File: rtl/pgm_ddram_arb.sv
// Three-port DDRAM arbiter: video/CPU single-beat reads with one-entry caches,
// loader writes first, and a starvation guard so video cannot lock out the CPU.
module pgm_ddram_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_rd,
  input  logic [28:0] vid_addr,
  output logic [63:0] vid_dout,
  output logic        vid_busy,
  output logic        vid_dout_ready,
  input  logic        cpu_rd,
  input  logic [28:0] cpu_addr,
  output logic [63:0] cpu_dout,
  output logic        cpu_busy,
  output logic        cpu_dout_ready,
  input  logic        ld_wr,
  input  logic [28:0] ld_addr,
  input  logic [63:0] ld_din,
  input  logic [7:0]  ld_be,
  output logic        ld_busy,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  output logic        DDRAM_RD,
  output logic        DDRAM_WE,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY
);

  typedef enum logic [2:0] {S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_RESP} state_t;
  state_t r_state, w_state_next;

  logic        r_vid_rd_d, r_cpu_rd_d;
  logic        r_vid_pend, r_cpu_pend;
  logic        r_vid_hit, r_cpu_hit;
  logic [28:0] r_vid_addr, r_cpu_addr;
  logic [28:0] r_vid_tag, r_cpu_tag;
  logic [63:0] r_vid_cdata, r_cpu_cdata;
  logic        r_vid_cval, r_cpu_cval;
  logic [63:0] r_vid_dout, r_cpu_dout;
  logic        r_vid_rdy, r_cpu_rdy;
  logic        r_ld_busy;
  logic [28:0] r_ld_addr;
  logic [63:0] r_ld_din;
  logic [7:0]  r_ld_be;
  logic [28:0] r_ddr_addr;
  logic        r_gnt_vid;
  logic [2:0]  r_starve;
  logic        r_drop;

  logic w_vid_cap, w_cpu_cap, w_ld_cap;
  logic w_vid_hit, w_cpu_hit;
  logic w_gnt_cpu, w_rd_grant, w_fill, w_fill_keep, w_inflight;

  assign w_vid_cap   = vid_rd & ~r_vid_rd_d;
  assign w_cpu_cap   = cpu_rd & ~r_cpu_rd_d;
  assign w_ld_cap    = ld_wr & ~r_ld_busy;
  // A write captured alongside a read forces the read to DDRAM so it sees fresh data
  assign w_vid_hit   = r_vid_cval && (vid_addr == r_vid_tag) && !w_ld_cap;
  assign w_cpu_hit   = r_cpu_cval && (cpu_addr == r_cpu_tag) && !w_ld_cap;
  assign w_gnt_cpu   = r_cpu_pend && (!r_vid_pend || (r_starve >= 3'd4));
  assign w_rd_grant  = (r_state == S_IDLE) && !r_ld_busy && (r_vid_pend || r_cpu_pend);
  assign w_fill      = (r_state == S_RD_WAIT) && DDRAM_DOUT_READY && !r_drop;
  assign w_fill_keep = !r_ld_busy && !w_ld_cap;
  assign w_inflight  = ((r_state == S_RD_ISSUE) && !DDRAM_BUSY) ||
                       ((r_state == S_RD_WAIT) && !DDRAM_DOUT_READY);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_ld_busy)                     w_state_next = S_WR_ISSUE;
        else if (r_vid_pend || r_cpu_pend) w_state_next = S_RD_ISSUE;
      end
      S_RD_ISSUE: if (!DDRAM_BUSY) w_state_next = S_RD_WAIT;
      S_RD_WAIT:  if (w_fill)      w_state_next = S_RESP;
      S_WR_ISSUE: if (!DDRAM_BUSY) w_state_next = S_IDLE;
      S_RESP:                      w_state_next = S_IDLE;
      default:                     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vid_rd_d  <= 1'b0;  r_cpu_rd_d  <= 1'b0;
      r_vid_pend  <= 1'b0;  r_cpu_pend  <= 1'b0;
      r_vid_hit   <= 1'b0;  r_cpu_hit   <= 1'b0;
      r_vid_addr  <= '0;    r_cpu_addr  <= '0;
      r_vid_tag   <= '0;    r_cpu_tag   <= '0;
      r_vid_cdata <= '0;    r_cpu_cdata <= '0;
      r_vid_cval  <= 1'b0;  r_cpu_cval  <= 1'b0;
      r_vid_dout  <= '0;    r_cpu_dout  <= '0;
      r_vid_rdy   <= 1'b0;  r_cpu_rdy   <= 1'b0;
      r_ld_busy   <= 1'b0;
      r_ld_addr   <= '0;
      r_ld_din    <= '0;
      r_ld_be     <= '0;
      r_ddr_addr  <= '0;
      r_gnt_vid   <= 1'b0;
      r_starve    <= '0;
      // Remember a read left outstanding so its late data is swallowed
      r_drop      <= w_inflight | (r_drop & ~DDRAM_DOUT_READY);
    end else begin
      r_vid_rd_d <= vid_rd;
      r_cpu_rd_d <= cpu_rd;
      r_vid_rdy  <= 1'b0;
      r_cpu_rdy  <= 1'b0;

      if (DDRAM_DOUT_READY && r_drop) r_drop <= 1'b0;

      if ((r_state == S_IDLE) && r_ld_busy) r_ddr_addr <= r_ld_addr;
      if (w_rd_grant) begin
        r_gnt_vid  <= !w_gnt_cpu;
        r_ddr_addr <= w_gnt_cpu ? r_cpu_addr : r_vid_addr;
        if (w_gnt_cpu)                          r_starve <= '0;
        else if (r_cpu_pend && r_starve != 3'd7) r_starve <= r_starve + 3'd1;
      end

      if ((r_state == S_WR_ISSUE) && !DDRAM_BUSY) r_ld_busy <= 1'b0;

      if (w_fill) begin
        if (r_gnt_vid) begin
          r_vid_dout  <= DDRAM_DOUT;
          r_vid_cdata <= DDRAM_DOUT;
          r_vid_tag   <= r_ddr_addr;
          r_vid_cval  <= w_fill_keep;
          r_vid_rdy   <= 1'b1;
        end else begin
          r_cpu_dout  <= DDRAM_DOUT;
          r_cpu_cdata <= DDRAM_DOUT;
          r_cpu_tag   <= r_ddr_addr;
          r_cpu_cval  <= w_fill_keep;
          r_cpu_rdy   <= 1'b1;
        end
      end

      if (r_state == S_RESP) begin
        if (r_gnt_vid) r_vid_pend <= 1'b0;
        else           r_cpu_pend <= 1'b0;
      end

      if (r_vid_hit) begin
        r_vid_hit  <= 1'b0;
        r_vid_dout <= r_vid_cdata;
        r_vid_rdy  <= 1'b1;
      end
      if (r_cpu_hit) begin
        r_cpu_hit  <= 1'b0;
        r_cpu_dout <= r_cpu_cdata;
        r_cpu_rdy  <= 1'b1;
      end

      // Captures come last so a new edge in the RESP cycle wins over the clear
      if (w_vid_cap) begin
        if (w_vid_hit) r_vid_hit <= 1'b1;
        else begin
          r_vid_pend <= 1'b1;
          r_vid_addr <= vid_addr;
        end
      end
      if (w_cpu_cap) begin
        if (w_cpu_hit) r_cpu_hit <= 1'b1;
        else begin
          r_cpu_pend <= 1'b1;
          r_cpu_addr <= cpu_addr;
        end
      end
      if (w_ld_cap) begin
        r_ld_busy  <= 1'b1;
        r_ld_addr  <= ld_addr;
        r_ld_din   <= ld_din;
        r_ld_be    <= ld_be;
        r_vid_cval <= 1'b0;
        r_cpu_cval <= 1'b0;
      end
    end
  end

  assign vid_dout       = r_vid_dout;
  assign cpu_dout       = r_cpu_dout;
  assign vid_dout_ready = r_vid_rdy;
  assign cpu_dout_ready = r_cpu_rdy;
  assign vid_busy       = r_vid_pend | r_vid_hit | r_vid_rdy;
  assign cpu_busy       = r_cpu_pend | r_cpu_hit | r_cpu_rdy;
  assign ld_busy        = r_ld_busy;

  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = r_ddr_addr;
  assign DDRAM_RD       = (r_state == S_RD_ISSUE);
  assign DDRAM_WE       = (r_state == S_WR_ISSUE);
  assign DDRAM_DIN      = r_ld_din;
  assign DDRAM_BE       = r_ld_be;

endmodule

// File: tb/tb_pgm_ddram_arb.sv
// Directed bench for pgm_ddram_arb: DDRAM responder model plus per-port
// expected-data queues checked whenever a dout_ready strobe appears.
module tb_pgm_ddram_arb;

  logic        clk, reset;
  logic        vid_rd, cpu_rd, ld_wr;
  logic [28:0] vid_addr, cpu_addr, ld_addr;
  logic [63:0] vid_dout, cpu_dout, ld_din;
  logic        vid_busy, vid_dout_ready, cpu_busy, cpu_dout_ready, ld_busy;
  logic [7:0]  ld_be;
  logic        DDRAM_BUSY, DDRAM_RD, DDRAM_WE, DDRAM_DOUT_READY;
  logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN, DDRAM_DOUT;

  pgm_ddram_arb dut (
    .clk(clk), .reset(reset),
    .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_dout(vid_dout),
    .vid_busy(vid_busy), .vid_dout_ready(vid_dout_ready),
    .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_busy(cpu_busy), .cpu_dout_ready(cpu_dout_ready),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_din(ld_din), .ld_be(ld_be), .ld_busy(ld_busy),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_RD(DDRAM_RD), .DDRAM_WE(DDRAM_WE), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
    .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 3;
  int rd_cnt   = 0;

  typedef struct { logic [28:0] a; int due; } rsp_t;
  rsp_t        rq[$];
  logic [63:0] vq[$];
  logic [63:0] cq[$];
  logic [28:0] acc_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem(input logic [28:0] a);
    if (a == 29'h0001000) return 64'h1122334455667788;
    return {3'd0, a, ~a, 3'd5};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DDRAM model: accepted reads answer lat cycles later, in order
  always @(negedge clk) begin
    if (DDRAM_RD && !DDRAM_BUSY) begin
      rq.push_back('{DDRAM_ADDR, cyc + lat});
      acc_q.push_back(DDRAM_ADDR);
      rd_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    DDRAM_DOUT_READY = 1'b0;
    if (rq.size() != 0 && rq[0].due == cyc) begin
      DDRAM_DOUT_READY = 1'b1;
      DDRAM_DOUT       = mem(rq[0].a);
      void'(rq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (DDRAM_RD || DDRAM_WE) chk("rd_we_exclusive", 128'(DDRAM_RD & DDRAM_WE), 128'(0));
    if (vid_dout_ready) begin
      chk("vid_rdy_expected", 128'(vq.size() != 0), 128'(1));
      if (vq.size() != 0) chk("vid_dout", 128'(vid_dout), 128'(vq.pop_front()));
    end
    if (cpu_dout_ready) begin
      chk("cpu_rdy_expected", 128'(cq.size() != 0), 128'(1));
      if (cq.size() != 0) chk("cpu_dout", 128'(cpu_dout), 128'(cq.pop_front()));
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ddr_ctl"}, 128'({DDRAM_RD, DDRAM_WE, DDRAM_BURSTCNT, DDRAM_BE, DDRAM_ADDR}),
        128'({1'b0, 1'b0, 8'd1, 8'd0, 29'd0}));
    chk({tag, "_ddr_din"}, 128'(DDRAM_DIN), 128'(0));
    chk({tag, "_douts"}, {vid_dout, cpu_dout}, 128'(0));
    chk({tag, "_flags"}, 128'({vid_dout_ready, cpu_dout_ready, vid_busy, cpu_busy, ld_busy}), 128'(0));
  endtask

  task automatic wait_vid(output int t);
    t = -1;
    for (int k = 0; k < 60 && t < 0; k++) begin
      @(negedge clk);
      if (vid_dout_ready) t = cyc;
    end
  endtask

  task automatic vid_txn(input logic [28:0] a, input int exp_lat, input int exp_rds,
                         input int hold, input string tag);
    int c, t, r0;
    r0 = rd_cnt;
    @(posedge clk); #1;
    vid_rd = 1'b1; vid_addr = a; c = cyc;
    vq.push_back(mem(a));
    wait_vid(t);
    chk({tag, "_latency"}, 128'(t - c), 128'(exp_lat));
    chk({tag, "_busy_at_rdy"}, 128'(vid_busy), 128'(1));
    @(negedge clk);
    chk({tag, "_busy_after"}, 128'(vid_busy), 128'(0));
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    vid_rd = 1'b0;
    repeat (8) @(negedge clk);
    chk({tag, "_rd_count"}, 128'(rd_cnt - r0), 128'(exp_rds));
  endtask

  task automatic ld_write(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
    @(posedge clk); #1;
    ld_wr = 1'b1; ld_addr = a; ld_din = d; ld_be = be;
    @(posedge clk); #1;
    ld_wr = 1'b0;
  endtask

  initial begin
    int c, t, r0, got, w;
    logic [28:0] ord[7];
    reset = 1'b1;
    vid_rd = 1'b0; cpu_rd = 1'b0; ld_wr = 1'b0;
    vid_addr = '0; cpu_addr = '0; ld_addr = '0; ld_din = '0; ld_be = '0;
    DDRAM_BUSY = 1'b0; DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Miss, then hit on the same word, then a write invalidates the cache
    vid_txn(29'h0001000, 6, 1, 3, "vid_miss");
    vid_txn(29'h0001000, 2, 0, 0, "vid_hit");
    ld_write(29'h0000500, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); if (!ld_busy) got = 1; end
    chk("ld_done", 128'(got), 128'(1));
    vid_txn(29'h0001000, 6, 1, 0, "vid_after_wr");

    // Starvation: CPU waits behind four video grants, then video resumes
    acc_q.delete();
    @(posedge clk); #1;
    vid_rd = 1'b1; vid_addr = 29'h300; vq.push_back(mem(29'h300));
    cpu_rd = 1'b1; cpu_addr = 29'h200; cq.push_back(mem(29'h200));
    for (int i = 0; i < 6; i++) begin
      got = 0;
      for (int k = 0; k < 80 && !got; k++) begin
        @(negedge clk);
        if (DDRAM_DOUT_READY && DDRAM_ADDR != 29'h200) got = 1;
      end
      chk("starve_wait", 128'(got), 128'(1));
      vid_rd = 1'b0;
      @(posedge clk); #1;
      if (i < 5) begin
        vid_rd = 1'b1; vid_addr = 29'h301 + 29'(i); vq.push_back(mem(29'h301 + 29'(i)));
      end
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    ord = '{29'h300, 29'h301, 29'h302, 29'h303, 29'h200, 29'h304, 29'h305};
    chk("starve_count", 128'(acc_q.size()), 128'(7));
    for (int i = 0; i < 7; i++)
      if (i < acc_q.size()) chk($sformatf("starve_order_%0d", i), 128'(acc_q[i]), 128'(ord[i]));

    // CPU cache hit
    repeat (2) @(negedge clk);
    r0 = rd_cnt;
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_addr = 29'h200; c = cyc; cq.push_back(mem(29'h200));
    t = -1;
    for (int k = 0; k < 40 && t < 0; k++) begin @(negedge clk); if (cpu_dout_ready) t = cyc; end
    chk("cpu_hit_latency", 128'(t - c), 128'(2));
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("cpu_hit_rd_count", 128'(rd_cnt - r0), 128'(0));

    // Write held off by waitrequest for 5 cycles
    @(posedge clk); #1;
    DDRAM_BUSY = 1'b1;
    ld_write(29'h0ABCDEF, 64'h0123456789ABCDEF, 8'h5A);
    w = 0;
    for (int k = 0; k < 20 && !w; k++) begin @(negedge clk); if (DDRAM_WE) w = 1; end
    chk("wr_issue_seen", 128'(w), 128'(1));
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("wr_stable_%0d", j), 128'({DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE}),
          128'({1'b1, 29'h0ABCDEF, 64'h0123456789ABCDEF, 8'h5A}));
    end
    @(posedge clk); #1;
    DDRAM_BUSY = 1'b0;
    @(negedge clk);
    chk("wr_accept_cycle", 128'({DDRAM_WE, ld_busy}), 128'(2'b11));
    @(negedge clk);
    chk("wr_after_accept", 128'({DDRAM_WE, ld_busy}), 128'(2'b00));

    // Reset during RD_WAIT; the stale data lands while the next read waits
    repeat (2) @(negedge clk);
    lat = 8;
    @(posedge clk); #1;
    vid_rd = 1'b1; vid_addr = 29'h0002000;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (DDRAM_RD && !DDRAM_BUSY) got = 1;
    end
    chk("rst_rd_accept", 128'(got), 128'(1));
    @(posedge clk); #1;
    reset = 1'b1; vid_rd = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");
    vid_txn(29'h0003000, 11, 1, 0, "post_reset_miss");
    lat = 3;

    repeat (20) @(negedge clk);
    chk("vid_queue_drained", 128'(vq.size()), 128'(0));
    chk("cpu_queue_drained", 128'(cq.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pgm_ddram_arb.md
# pgm_ddram_arb

Three-port arbiter between the PGM core's DDRAM clients and the MiSTer DDRAM Avalon port. Serves the video engine's graphics-ROM reads, 68000 program-ROM reads, and the ROM loader's writes, one single-beat transaction at a time. The video port and CPU port each keep a one-entry last-word cache. A starvation guard keeps video priority from locking out the CPU.

## Interface
- No parameters.
- clk  in  1  system clock; reset: `reset` (synchronous, active-high); `clk` is the clock
- reset  in  1  synchronous, active-high
- vid_rd  in  1  video read request; level held until vid_dout_ready is seen
- vid_addr  in  29  video word address, valid with vid_rd
- vid_dout  out  64  video read data
- vid_busy  out  1  video port occupied
- vid_dout_ready  out  1  one-cycle data strobe to video
- cpu_rd  in  1  CPU read request (same protocol as vid_rd)
- cpu_addr  in  29  CPU word address
- cpu_dout  out  64  CPU read data
- cpu_busy  out  1  CPU port occupied
- cpu_dout_ready  out  1  one-cycle data strobe to CPU
- ld_wr  in  1  loader write strobe, accepted only when ld_busy=0
- ld_addr  in  29  loader word address
- ld_din  in  64  loader data
- ld_be  in  8  loader byte enables
- ld_busy  out  1  loader write pending
- DDRAM_BUSY  in  1  Avalon waitrequest
- DDRAM_BURSTCNT  out  8  burst length, constant 1
- DDRAM_ADDR  out  29  Avalon address
- DDRAM_RD  out  1  Avalon read
- DDRAM_WE  out  1  Avalon write
- DDRAM_DIN  out  64  write data
- DDRAM_BE  out  8  byte enables
- DDRAM_DOUT  in  64  read data
- DDRAM_DOUT_READY  in  1  read data valid

## Operation
- Request capture:
  - A read is captured on the rising edge of vid_rd or cpu_rd (1 now, 0 last cycle). The address is latched into that port's pending register.
  - A held level is never recaptured. This protects against the requester deasserting rd one cycle after dout_ready.
- A loader write is captured when ld_wr=1 and ld_busy=0. ld_busy goes high the next cycle and stays high until the Avalon write is accepted.
- Cache hit path:
  - Each read port has a cache: tag (29b), data (64b), valid.
  - A captured read whose address equals a valid tag completes without DDRAM access. dout is driven and dout_ready pulses 2 cycles after capture.
- Any accepted loader write clears both cache valid bits.
- Grant order in IDLE:
  - Pending write, then pending video, then pending CPU.
  - Starvation counter (3b): increments on each video grant while CPU is pending, and clears on a CPU grant.
  - At count 4 the CPU wins over video.
- FSM states:
  - IDLE: select a grant, drive DDRAM_ADDR, go to RD_ISSUE or WR_ISSUE.
  - RD_ISSUE: DDRAM_RD=1 until a cycle with DDRAM_BUSY=0, then go to RD_WAIT.
  - WR_ISSUE: DDRAM_WE=1 with DIN/BE until a cycle with DDRAM_BUSY=0, then go to IDLE and clear ld_busy.
  - RD_WAIT: on DDRAM_DOUT_READY, latch data into the granted port's dout and cache, set valid, go to RESP.
  - RESP: pulse the granted port's dout_ready for 1 cycle, clear its pending flag, go to IDLE.
- Port busy signals:
  - vid_busy / cpu_busy = pending flag OR response in flight.
  - They stay high through the dout_ready cycle and drop on the cycle after it.
- Avalon rules:
  - DDRAM_RD and DDRAM_WE are never both high.
  - Address, DIN and BE are stable while the strobe is held under busy.
- Reset mid-transaction:
  - All state returns to IDLE; pending flags, caches and counters clear.
  - A DDRAM_DOUT_READY arriving after reset is ignored; a one-bit drop flag is set while a read is in flight at reset.

## Timing
- Reset values: DDRAM_RD=0, DDRAM_WE=0, DDRAM_BURSTCNT=1, DDRAM_ADDR=0, DDRAM_DIN=0, DDRAM_BE=0, all dout=0, all dout_ready=0, all busy=0.
- Miss latency, DDRAM_BUSY=0 and DDRAM data returning L cycles after RD:
  - capture C; IDLE grant C+1; RD high C+2; data at C+2+L; dout_ready at C+3+L.
- Hit latency: dout_ready at C+2.
- A rising request edge in the same cycle as that port's dout_ready is captured normally.
- A write and a read capturing in the same cycle: both are latched; the write issues first.

## Test plan
- Video miss, addr 0x0001000, DDRAM returns 0x1122334455667788 with L=3 -> vid_dout_ready one cycle at C+6 with that data, vid_busy low at C+7, exactly one DDRAM_RD.
- Same video address re-requested -> dout_ready at C+2, no DDRAM_RD. Then ld_wr to any address, then the same read again -> DDRAM_RD issued.
- vid_rd held high 3 cycles past dout_ready -> no second capture, a single DDRAM_RD only.
- CPU pending while video issues 6 back-to-back misses -> CPU is granted after the 4th video grant, then video resumes.
- DDRAM_BUSY held high 5 cycles during a write -> DDRAM_WE, ADDR, DIN and BE stable for all 5 cycles, ld_busy clears the cycle after acceptance.
- Reset asserted in RD_WAIT, then late DDRAM_DOUT_READY -> no dout_ready pulse, all outputs at reset values.
